// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU; single-cycle arithmetic/logic ops, shifts iterate SHIFT_STEP bits per cycle.
module ula_multiciclo #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ula_select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             invalid_op,
  output logic             busy,
  output logic             done
);
  localparam int LW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] acc_q, acc_d, alu_d;
  logic [LW-1:0]    rem_q, step_d, shamt;
  logic [1:0]       kind_q, kind_d;
  logic             is_shift, valid, last;
  always_comb begin
    shamt    = b[LW-1:0];
    is_shift = ula_select == 4'b0011 || ula_select == 4'b0110 || ula_select == 4'b0111;
    valid    = ula_select inside {[4'd1:4'd12]};
    kind_d   = ula_select == 4'b0011 ? 2'd0 : ula_select == 4'b0110 ? 2'd1 : 2'd2;
    alu_d    = (ula_select == 4'b0001 || ula_select == 4'b1100) ? a + b :
               ula_select == 4'b0010 ? a - b :
               ula_select == 4'b0100 ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
               ula_select == 4'b0101 ? {{(WIDTH-1){1'b0}}, a < b} :
               ula_select == 4'b1000 ? a ^ b :
               ula_select == 4'b1001 ? a | b :
               ula_select == 4'b1010 ? a & b :
               ula_select == 4'b1011 ? b :
               is_shift ? a : '0;
    // the final step may be shorter than SHIFT_STEP
    step_d   = rem_q < LW'(SHIFT_STEP) ? rem_q : LW'(SHIFT_STEP);
    last     = rem_q <= LW'(SHIFT_STEP);
    acc_d    = kind_q == 2'd0 ? acc_q << step_d :
               kind_q == 2'd1 ? acc_q >> step_d : WIDTH'($signed(acc_q) >>> step_d);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      rem_q      <= '0;
      kind_q     <= 2'd0;
      result     <= '0;
      zero       <= 1'b1;
      invalid_op <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (valid && is_shift && shamt != '0) begin
            acc_q   <= a;
            rem_q   <= shamt;
            kind_q  <= kind_d;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end else begin
            result     <= alu_d;
            zero       <= alu_d == '0;
            invalid_op <= !valid;
            done       <= 1'b1;
            state_q    <= DONE;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          rem_q <= rem_q - step_d;
          if (last) begin
            result     <= acc_d;
            zero       <= acc_d == '0;
            invalid_op <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: checks SHIFT_STEP=1 and SHIFT_STEP=4 instances against a behavioural model.
module tb_ula_multiciclo;
  logic        clk, rst, start;
  logic [3:0]  ula_select;
  logic [31:0] a, b;
  logic [31:0] res_w[2];
  logic        zero_w[2], inv_w[2], busy_w[2], done_w[2];
  int          checks = 0, errors = 0;
  int          step_p[2] = '{1, 4};
  logic [31:0] m_res[2], m_pend[2];
  logic        m_zero[2], m_inv[2], m_busy[2], m_done[2];
  int          m_cnt[2];
  ula_multiciclo #(.WIDTH(32), .SHIFT_STEP(1)) u1 (.clk(clk), .rst(rst), .start(start),
    .ula_select(ula_select), .a(a), .b(b), .result(res_w[0]), .zero(zero_w[0]),
    .invalid_op(inv_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  ula_multiciclo #(.WIDTH(32), .SHIFT_STEP(4)) u4 (.clk(clk), .rst(rst), .start(start),
    .ula_select(ula_select), .a(a), .b(b), .result(res_w[1]), .zero(zero_w[1]),
    .invalid_op(inv_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_res(logic [3:0] s, logic [31:0] x, logic [31:0] y);
    case (s)
      4'd1, 4'd12: return x + y;
      4'd2:  return x - y;
      4'd3:  return x << y[4:0];
      4'd4:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd5:  return (x < y) ? 32'd1 : 32'd0;
      4'd6:  return x >> y[4:0];
      4'd7:  return $signed(x) >>> y[4:0];
      4'd8:  return x ^ y;
      4'd9:  return x | y;
      4'd10: return x & y;
      4'd11: return y;
      default: return 32'd0;
    endcase
  endfunction
  function automatic int ref_lat(logic [3:0] s, logic [31:0] y, int st);
    if ((s == 4'd3 || s == 4'd6 || s == 4'd7) && y[4:0] != 5'd0)
      return 1 + (int'(y[4:0]) + st - 1) / st;
    return 1;
  endfunction
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_res[i] <= 0; m_zero[i] <= 1; m_inv[i] <= 0; m_busy[i] <= 0; m_done[i] <= 0;
        m_cnt[i] <= 0; m_pend[i] <= 0;
      end else begin
        m_done[i] <= 0;
        if (m_busy[i]) begin
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) begin
            m_busy[i] <= 0; m_done[i] <= 1; m_res[i] <= m_pend[i];
            m_zero[i] <= m_pend[i] == 0; m_inv[i] <= 0;
          end
        end else if (!m_done[i] && start) begin
          if (ref_lat(ula_select, b, step_p[i]) == 1) begin
            m_done[i] <= 1;
            m_res[i]  <= ref_res(ula_select, a, b);
            m_zero[i] <= ref_res(ula_select, a, b) == 0;
            m_inv[i]  <= !(ula_select inside {[4'd1:4'd12]});
          end else begin
            m_busy[i] <= 1;
            m_cnt[i]  <= ref_lat(ula_select, b, step_p[i]) - 1;
            m_pend[i] <= ref_res(ula_select, a, b);
          end
        end
      end
    end
  end
  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %h want %h", nm, i, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("result", i, res_w[i], m_res[i]);
      chk("zero", i, 32'(zero_w[i]), 32'(m_zero[i]));
      chk("invalid_op", i, 32'(inv_w[i]), 32'(m_inv[i]));
      chk("busy", i, 32'(busy_w[i]), 32'(m_busy[i]));
      chk("done", i, 32'(done_w[i]), 32'(m_done[i]));
    end
  end
  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (!busy_w[0] && !done_w[0] && !busy_w[1] && !done_w[1]) break;
    end
    if (k == 200) chk("idle_timeout", 0, 32'd1, 32'd0);
  endtask
  task automatic do_op(string nm, logic [3:0] s, logic [31:0] aa, logic [31:0] bb,
                       logic [31:0] er, int l1, int l4, logic ei, bit noise);
    int n, got1, got4;
    logic [31:0] r1, r4;
    logic i1;
    wait_idle();
    ula_select = s; a = aa; b = bb; start = 1;
    @(posedge clk); #1;
    start = 0;
    got1 = -1; got4 = -1; r1 = 'x; r4 = 'x; i1 = 1'bx;
    for (n = 1; n <= 100 && (got1 < 0 || got4 < 0); n++) begin
      if (done_w[0] && got1 < 0) begin got1 = n; r1 = res_w[0]; i1 = inv_w[0]; end
      if (done_w[1] && got4 < 0) begin got4 = n; r4 = res_w[1]; end
      if (got1 < 0 || got4 < 0) begin
        if (noise) begin
          a = $urandom; b = $urandom; ula_select = 4'($urandom); start = $urandom_range(0, 1) == 1;
        end
        @(posedge clk); #1;
      end
    end
    start = 0;
    chk({nm, "_lat"}, 0, 32'(got1), 32'(l1));
    chk({nm, "_lat"}, 1, 32'(got4), 32'(l4));
    chk({nm, "_res"}, 0, r1, er);
    chk({nm, "_res"}, 1, r4, er);
    chk({nm, "_inv"}, 0, 32'(i1), 32'(ei));
  endtask
  initial begin
    rst = 1; start = 0; ula_select = 0; a = 0; b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 0, res_w[0], 32'd0);
    chk("rst_zero", 0, 32'(zero_w[0]), 32'd1);
    rst = 0;
    do_op("add", 4'd1, 32'h7fffffff, 32'h1, 32'h80000000, 1, 1, 0, 0);
    chk("add_zero", 0, 32'(zero_w[0]), 32'd0);
    do_op("sub", 4'd2, 32'h5, 32'h5, 32'h0, 1, 1, 0, 0);
    chk("sub_zero", 0, 32'(zero_w[0]), 32'd1);
    do_op("slt", 4'd4, 32'hffffffff, 32'h1, 32'h1, 1, 1, 0, 0);
    do_op("sltu", 4'd5, 32'hffffffff, 32'h1, 32'h0, 1, 1, 0, 0);
    do_op("sra31", 4'd7, 32'h80000000, 32'h1f, 32'hffffffff, 32, 9, 0, 0);
    do_op("sll0", 4'd3, 32'h12345678, 32'h20, 32'h12345678, 1, 1, 0, 0);
    do_op("srl_noise", 4'd6, 32'hf0000000, 32'h8, 32'h00f00000, 9, 3, 0, 1);
    do_op("lui", 4'd11, 32'h1, 32'habcde000, 32'habcde000, 1, 1, 0, 0);
    do_op("auipc", 4'd12, 32'h1000, 32'h2000, 32'h3000, 1, 1, 0, 0);
    do_op("inval", 4'd14, 32'h3, 32'h4, 32'h0, 1, 1, 1, 0);
    do_op("add_clr", 4'd1, 32'h2, 32'h3, 32'h5, 1, 1, 0, 0);
    wait_idle();
    ula_select = 4'd6; a = 32'hffffffff; b = 32'h10; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", 0, 32'(busy_w[0]), 32'd1);
    #2 rst = 1;
    #1;
    chk("arst_result", 0, res_w[0], 32'd0);
    chk("arst_zero", 0, 32'(zero_w[0]), 32'd1);
    chk("arst_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("arst_done", 0, 32'(done_w[0]), 32'd0);
    #2 rst = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", 0, 32'(done_w[0]), 32'd0);
    end
    do_op("add_after_rst", 4'd1, 32'h1, 32'h1, 32'h2, 1, 1, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      start = $urandom_range(0, 2) == 0;
      ula_select = 4'($urandom);
      case ($urandom_range(0, 4))
        0: a = 32'h80000000;
        1: a = 32'h7fffffff;
        2: a = 32'hffffffff;
        3: a = 32'h0;
        default: a = $urandom;
      endcase
      b = $urandom_range(0, 3) == 0 ? a : $urandom;
      if ($urandom_range(0, 799) == 0) begin
        #2 rst = 1;
        #4 rst = 0;
      end
    end
    start = 0;
    repeat (40) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
